// File: rtl/baud_rate_controller.sv
// UART baud-rate tick generator: a 16x oversample tick plus a bit-rate tick, with a
// run-time divisor that is only swapped in once the serial link is between frames.
module baud_rate_controller #(
    parameter logic [15:0] DEFAULT_DIV = 16'd625,
    parameter int          OVERSAMPLE  = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        LINK_BUSY,
    input  logic        CFG_WR,
    input  logic [15:0] CFG_DIV,
    output logic        CFG_BUSY,
    output logic        CFG_ACK,
    output logic        CFG_ERR,
    output logic [15:0] DIV_ACTIVE,
    output logic        TICK_16X,
    output logic        TICK_1X
);

    localparam int            OS_W    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       div_pend;
    logic [15:0]       div_cnt;
    logic [OS_W-1:0]   os_cnt;
    logic              div_ok;
    logic              accept;
    logic              reject;
    logic              apply;
    logic              div_wrap;
    logic              os_wrap;

    // A divisor of 0 or 1 cannot produce a distinct tick period.
    function automatic logic div_legal(input logic [15:0] d);
        return d >= 16'd2;
    endfunction

    assign div_ok   = div_legal(CFG_DIV);
    assign div_wrap = (div_cnt == (DIV_ACTIVE - 16'd1));
    assign os_wrap  = (os_cnt == OS_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CFG_WR && div_ok) state_nxt = PEND;
            PEND:    if (!LINK_BUSY)       state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        CFG_BUSY = (state != IDLE);
        accept   = (state == IDLE) && CFG_WR && div_ok;
        reject   = CFG_WR && !accept;
        apply    = (state == APPLY);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_pend   <= DEFAULT_DIV;
            DIV_ACTIVE <= DEFAULT_DIV;
            CFG_ACK    <= 1'b0;
            CFG_ERR    <= 1'b0;
        end else begin
            CFG_ACK <= apply;
            CFG_ERR <= reject;
            if (accept) begin
                div_pend <= CFG_DIV;
            end
            if (apply) begin
                DIV_ACTIVE <= div_pend;
            end
        end
    end

    // Applying a new divisor restarts both counters and wins over a coincident wrap.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt  <= '0;
            os_cnt   <= '0;
            TICK_16X <= 1'b0;
            TICK_1X  <= 1'b0;
        end else if (apply || !ENABLE) begin
            div_cnt  <= '0;
            os_cnt   <= '0;
            TICK_16X <= 1'b0;
            TICK_1X  <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            TICK_16X <= 1'b1;
            if (os_wrap) begin
                os_cnt  <= '0;
                TICK_1X <= 1'b1;
            end else begin
                os_cnt  <= os_cnt + 1'b1;
                TICK_1X <= 1'b0;
            end
        end else begin
            div_cnt  <= div_cnt + 16'd1;
            TICK_16X <= 1'b0;
            TICK_1X  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_rate_controller.sv
// Directed bench for baud_rate_controller: expected divisors and tick intervals are
// queued when stimulus is applied and consumed when the DUT acknowledges or ticks.
module tb_baud_rate_controller;

    logic        CLK;
    logic        RST;
    logic        ENABLE;
    logic        LINK_BUSY;
    logic        CFG_WR;
    logic [15:0] CFG_DIV;
    logic        CFG_BUSY;
    logic        CFG_ACK;
    logic        CFG_ERR;
    logic [15:0] DIV_ACTIVE;
    logic        TICK_16X;
    logic        TICK_1X;

    int tests = 0;
    int fails = 0;
    int exp_div_q[$];
    int exp_per_q[$];

    baud_rate_controller #(
        .DEFAULT_DIV(16'd625),
        .OVERSAMPLE (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ENABLE    (ENABLE),
        .LINK_BUSY (LINK_BUSY),
        .CFG_WR    (CFG_WR),
        .CFG_DIV   (CFG_DIV),
        .CFG_BUSY  (CFG_BUSY),
        .CFG_ACK   (CFG_ACK),
        .CFG_ERR   (CFG_ERR),
        .DIV_ACTIVE(DIV_ACTIVE),
        .TICK_16X  (TICK_16X),
        .TICK_1X   (TICK_1X)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_cfg(input logic [15:0] d);
        CFG_WR  = 1'b1;
        CFG_DIV = d;
        step();
        CFG_WR  = 1'b0;
    endtask

    task automatic expect_ack(input string tag);
        check({tag, "_ack"}, CFG_ACK, 1);
        if (exp_div_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_sb observed=ack expected=no_pending_divisor", tag);
        end else begin
            check({tag, "_div"}, DIV_ACTIVE, exp_div_q.pop_front());
        end
    endtask

    task automatic wait_tick(input bit one_x, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((one_x ? TICK_1X : TICK_16X) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_period(input string tag, input bit one_x, input int budget);
        int n;
        int exp;
        exp = exp_per_q.pop_front();
        wait_tick(one_x, budget, n);
        check(tag, n, exp);
    endtask

    initial begin
        int bad;
        RST = 1'b0; ENABLE = 1'b0; LINK_BUSY = 1'b0; CFG_WR = 1'b0; CFG_DIV = '0;
        repeat (3) step();
        check("rst_busy", CFG_BUSY, 0);
        check("rst_ack", CFG_ACK, 0);
        check("rst_err", CFG_ERR, 0);
        check("rst_t16", TICK_16X, 0);
        check("rst_t1", TICK_1X, 0);
        check("rst_div", DIV_ACTIVE, 625);
        RST = 1'b1;
        step();
        check("idle_t16", TICK_16X, 0);

        // default-rate run
        ENABLE = 1'b1;
        exp_per_q.push_back(625);  check_period("dflt_first16", 0, 700);
        exp_per_q.push_back(625);  check_period("dflt_per16", 0, 700);
        exp_per_q.push_back(8750); check_period("dflt_first1x", 1, 9000);
        check("dflt_1x_with_16x", TICK_16X, 1);
        exp_per_q.push_back(10000); check_period("dflt_per1x", 1, 10100);
        check("dflt_div", DIV_ACTIVE, 625);

        // deferred apply while link busy
        LINK_BUSY = 1'b1;
        exp_div_q.push_back(8);
        write_cfg(16'd8);
        check("def_busy_n1", CFG_BUSY, 1);
        bad = 0;
        repeat (15) begin
            step();
            if (CFG_BUSY !== 1'b1 || DIV_ACTIVE !== 16'd625 || CFG_ACK !== 1'b0) bad++;
        end
        check("def_hold", bad, 0);
        LINK_BUSY = 1'b0;
        step();
        check("def_busy_m1", CFG_BUSY, 1);
        check("def_noack_m1", CFG_ACK, 0);
        step();
        expect_ack("def");
        check("def_busy_m2", CFG_BUSY, 0);

        // idle reconfiguration issued in the ack cycle
        exp_div_q.push_back(4);
        write_cfg(16'd4);
        check("idl_busy_n1", CFG_BUSY, 1);
        check("idl_err_n1", CFG_ERR, 0);
        step();
        check("idl_busy_n2", CFG_BUSY, 1);
        check("idl_noack_n2", CFG_ACK, 0);
        step();
        expect_ack("idl");
        check("idl_busy_n3", CFG_BUSY, 0);
        check("idl_t16_apply", TICK_16X, 0);
        exp_per_q.push_back(4);  check_period("idl_first16", 0, 20);
        exp_per_q.push_back(4);  check_period("idl_per16", 0, 20);
        exp_per_q.push_back(56); check_period("idl_first1x", 1, 100);
        exp_per_q.push_back(64); check_period("idl_per1x", 1, 100);

        // apply lands on the same edge as a divide-counter wrap
        step();
        exp_div_q.push_back(5);
        write_cfg(16'd5);
        step();
        step();
        expect_ack("col");
        check("col_t16", TICK_16X, 0);
        exp_per_q.push_back(5); check_period("col_first16", 0, 20);

        // illegal divisor, then a second write while pending
        write_cfg(16'd1);
        check("rej1_err", CFG_ERR, 1);
        check("rej1_busy", CFG_BUSY, 0);
        step();
        check("rej1_err_clr", CFG_ERR, 0);
        check("rej1_div", DIV_ACTIVE, 5);
        LINK_BUSY = 1'b1;
        exp_div_q.push_back(6);
        write_cfg(16'd6);
        write_cfg(16'd9);
        check("rej2_err", CFG_ERR, 1);
        check("rej2_busy", CFG_BUSY, 1);
        check("rej2_div", DIV_ACTIVE, 5);
        LINK_BUSY = 1'b0;
        step();
        check("rej2_err_clr", CFG_ERR, 0);
        step();
        expect_ack("rej2");

        // enable gating mid-count
        exp_per_q.push_back(6); check_period("gate_pre16", 0, 20);
        step();
        step();
        ENABLE = 1'b0;
        step();
        check("gate_t16", TICK_16X, 0);
        check("gate_div_cnt", dut.div_cnt, 0);
        check("gate_os_cnt", dut.os_cnt, 0);
        bad = 0;
        repeat (20) begin
            step();
            if (TICK_16X !== 1'b0 || TICK_1X !== 1'b0) bad++;
        end
        check("gate_quiet", bad, 0);
        ENABLE = 1'b1;
        exp_per_q.push_back(6); check_period("gate_resume", 0, 20);

        // reset asserted while a divisor is pending
        LINK_BUSY = 1'b1;
        write_cfg(16'd10);
        check("rstp_busy_pre", CFG_BUSY, 1);
        #1 RST = 1'b0;
        #1;
        check("rstp_busy", CFG_BUSY, 0);
        check("rstp_div", DIV_ACTIVE, 625);
        check("rstp_t16", TICK_16X, 0);
        step();
        RST = 1'b1;
        LINK_BUSY = 1'b0;
        bad = 0;
        repeat (4) begin
            step();
            if (CFG_ACK !== 1'b0 || CFG_BUSY !== 1'b0) bad++;
        end
        check("rstp_no_apply", bad, 0);
        check("rstp_div_after", DIV_ACTIVE, 625);
        check("sb_drained", exp_div_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
